// File: rtl/full_add.sv
// full_add: 1-bit full adder with a combinational path, a registered
// path qualified by in_valid, and optional saturating statistics.
//
// Ports:
//   clk, rst_n      - rising-edge clock, async active-low reset
//   a, b, c         - addends and carry-in
//   sum, carry      - combinational result (no clock, no reset)
//   in_valid        - capture a/b/c result at next rising edge
//   out_valid       - sum_q/carry_q hold a freshly captured result
//   sum_q, carry_q  - registered result, held while in_valid = 0
//   op_cnt          - accepted operations (saturating)
//   carry_cnt       - accepted operations with carry-out = 1 (saturating)
//
// Build option: define FULL_ADD_STATS_EN to implement op_cnt and
// carry_cnt; otherwise both ports are tied to zero and no counter
// flops exist.
module full_add #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             sum,
  output logic             carry,
  input  logic             in_valid,
  output logic             out_valid,
  output logic             sum_q,
  output logic             carry_q,
  output logic [CNT_W-1:0] op_cnt,
  output logic [CNT_W-1:0] carry_cnt
);

  logic w_sum;
  logic w_carry;

  logic r_vld;
  logic r_sum;
  logic r_carry;

  assign w_sum   = a ^ b ^ c;
  assign w_carry = (a & b) | (a & c) | (b & c);

  assign sum   = w_sum;
  assign carry = w_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld   <= 1'b0;
      r_sum   <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      r_vld <= in_valid;
      if (in_valid) begin
        r_sum   <= w_sum;
        r_carry <= w_carry;
      end
    end
  end

  assign out_valid = r_vld;
  assign sum_q     = r_sum;
  assign carry_q   = r_carry;

`ifdef FULL_ADD_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_op_cnt;
  logic [CNT_W-1:0] r_carry_cnt;

  // Both counters share one ceiling and carry_cnt only advances
  // on accepted ops, so carry_cnt can never pass op_cnt.
  // a/b/c are only looked at when in_valid is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_cnt    <= '0;
      r_carry_cnt <= '0;
    end else if (in_valid) begin
      if (r_op_cnt != CNT_MAX)
        r_op_cnt <= r_op_cnt + CNT_ONE;
      if (w_carry && (r_carry_cnt != CNT_MAX))
        r_carry_cnt <= r_carry_cnt + CNT_ONE;
    end
  end

  assign op_cnt    = r_op_cnt;
  assign carry_cnt = r_carry_cnt;
`else
  assign op_cnt    = '0;
  assign carry_cnt = '0;
`endif

endmodule

// File: tb/tb_full_add.sv
// tb_full_add: self-checking bench for full_add, two instances
// (CNT_W=8 and CNT_W=4) driven from the same inputs.
module tb_full_add;

`ifdef FULL_ADD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n = 1'b0;
  logic a = 1'b0;
  logic b = 1'b0;
  logic c = 1'b0;
  logic in_valid = 1'b0;

  logic sum, carry, out_valid, sum_q, carry_q;
  logic [7:0] op_cnt, carry_cnt;
  logic sum4, carry4, out_valid4, sum_q4, carry_q4;
  logic [3:0] op_cnt4, carry_cnt4;

  int checks = 0;
  int failures = 0;

  bit m_vld, m_sq, m_cq;
  int m_op8, m_cc8, m_op4, m_cc4;

  always #5 if (clk_en) clk = ~clk;

  full_add dut (
    .clk(clk), .rst_n(rst_n),
    .a(a), .b(b), .c(c),
    .sum(sum), .carry(carry),
    .in_valid(in_valid), .out_valid(out_valid),
    .sum_q(sum_q), .carry_q(carry_q),
    .op_cnt(op_cnt), .carry_cnt(carry_cnt)
  );

  full_add #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .a(a), .b(b), .c(c),
    .sum(sum4), .carry(carry4),
    .in_valid(in_valid), .out_valid(out_valid4),
    .sum_q(sum_q4), .carry_q(carry_q4),
    .op_cnt(op_cnt4), .carry_cnt(carry_cnt4)
  );

  function automatic void model_clear();
    m_vld = 0; m_sq = 0; m_cq = 0;
    m_op8 = 0; m_cc8 = 0; m_op4 = 0; m_cc4 = 0;
  endfunction

  // One rising edge worth of behaviour, from the arithmetic rules.
  function automatic void model_edge();
    int t;
    if (in_valid === 1'b1) begin
      t = int'(a) + int'(b) + int'(c);
      m_vld = 1;
      m_sq = (t % 2) == 1;
      m_cq = t >= 2;
      m_op8 = (m_op8 < 255) ? m_op8 + 1 : 255;
      m_op4 = (m_op4 < 15) ? m_op4 + 1 : 15;
      if (m_cq) begin
        m_cc8 = (m_cc8 < 255) ? m_cc8 + 1 : 255;
        m_cc4 = (m_cc4 < 15) ? m_cc4 + 1 : 15;
      end
    end else begin
      m_vld = 0;
    end
  endfunction

  function automatic logic [29:0] exp_regs();
    logic [7:0] o8, c8;
    logic [3:0] o4, c4;
    o8 = STATS ? 8'(m_op8) : 8'd0;
    c8 = STATS ? 8'(m_cc8) : 8'd0;
    o4 = STATS ? 4'(m_op4) : 4'd0;
    c4 = STATS ? 4'(m_cc4) : 4'd0;
    return {m_vld, m_sq, m_cq, o8, c8,
            m_vld, m_sq, m_cq, o4, c4};
  endfunction

  function automatic logic [29:0] act_regs();
    return {out_valid, sum_q, carry_q, op_cnt, carry_cnt,
            out_valid4, sum_q4, carry_q4, op_cnt4, carry_cnt4};
  endfunction

  function automatic logic [3:0] exp_comb();
    int t;
    logic s, k;
    t = int'(a) + int'(b) + int'(c);
    s = (t % 2) == 1;
    k = t >= 2;
    return {s, k, s, k};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    model_clear();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (act_regs() !== 30'd0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", act_regs(), 30'd0);
    end
  endtask

  task automatic test_truth_table();
    logic [2:0] v;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {a, b, c} = v;
      #1;
      checks++;
      if ({sum, carry, sum4, carry4} !== exp_comb()) begin
        failures++;
        $display("FAIL truth_table abc=%b got=%b exp=%b",
                 v, {sum, carry, sum4, carry4}, exp_comb());
      end
      checks++;
      if (act_regs() !== 30'd0) begin
        failures++;
        $display("FAIL truth_table_regs abc=%b got=%h exp=0",
                 v, act_regs());
      end
      #9;
    end
  endtask

  task automatic test_registered();
    a = 1; b = 1; c = 0; in_valid = 1;
    step();
    checks++;
    if ({out_valid, sum_q, carry_q} !== 3'b101 ||
        act_regs() !== exp_regs()) begin
      failures++;
      $display("FAIL registered_load got=%h exp=%h",
               act_regs(), exp_regs());
    end
    a = 0; b = 0; c = 0; in_valid = 0;
    step();
    checks++;
    if ({out_valid, sum_q, carry_q} !== 3'b001 ||
        act_regs() !== exp_regs()) begin
      failures++;
      $display("FAIL registered_hold got=%h exp=%h",
               act_regs(), exp_regs());
    end
  endtask

  task automatic test_stats();
    logic [2:0] v;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {a, b, c} = v;
      in_valid = 1;
      step();
      checks++;
      if (act_regs() !== exp_regs()) begin
        failures++;
        $display("FAIL stats_op%0d got=%h exp=%h",
                 i, act_regs(), exp_regs());
      end
    end
    in_valid = 0;
    step();
    checks++;
    if (op_cnt !== (STATS ? 8'd8 : 8'd0) ||
        carry_cnt !== (STATS ? 8'd4 : 8'd0)) begin
      failures++;
      $display("FAIL stats_total op=%0d carry=%0d exp_op=%0d exp_carry=%0d",
               op_cnt, carry_cnt, STATS ? 8 : 0, STATS ? 4 : 0);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      in_valid = 1;
      step();
      checks++;
      if (out_valid !== 1'b1 || act_regs() !== exp_regs()) begin
        failures++;
        $display("FAIL back_to_back_%0d got=%h exp=%h",
                 i, act_regs(), exp_regs());
      end
    end
    in_valid = 0;
  endtask

  task automatic test_x_idle();
    in_valid = 0;
    a = 1'bx; b = 1'bz; c = 1'bx;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (act_regs() !== exp_regs()) begin
        failures++;
        $display("FAIL x_idle_%0d got=%h exp=%h",
                 i, act_regs(), exp_regs());
      end
    end
    a = 0; b = 0; c = 0;
  endtask

  task automatic test_saturation();
    do_reset();
    a = 1; b = 1; c = 1; in_valid = 1;
    repeat (20) step();
    in_valid = 0;
    step();
    checks++;
    if (op_cnt4 !== (STATS ? 4'd15 : 4'd0) ||
        carry_cnt4 !== (STATS ? 4'd15 : 4'd0) ||
        op_cnt !== (STATS ? 8'd20 : 8'd0)) begin
      failures++;
      $display("FAIL saturation op4=%0d carry4=%0d op8=%0d",
               op_cnt4, carry_cnt4, op_cnt);
    end
    checks++;
    if (act_regs() !== exp_regs()) begin
      failures++;
      $display("FAIL saturation_regs got=%h exp=%h",
               act_regs(), exp_regs());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a = 1; b = 1'(i); c = 1;
      in_valid = 1;
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    checks++;
    if (act_regs() !== 30'd0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0", act_regs());
    end
    a = 1; b = 0; c = 0;
    #1;
    checks++;
    if ({sum, carry, sum4, carry4} !== exp_comb()) begin
      failures++;
      $display("FAIL reset_comb got=%b exp=%b",
               {sum, carry, sum4, carry4}, exp_comb());
    end
    @(negedge clk);
    checks++;
    if (act_regs() !== 30'd0) begin
      failures++;
      $display("FAIL reset_held got=%h exp=0", act_regs());
    end
    rst_n = 1'b1;
    a = 1; b = 0; c = 1; in_valid = 1;
    step();
    checks++;
    if (out_valid !== 1'b1 || act_regs() !== exp_regs()) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h",
               act_regs(), exp_regs());
    end
    in_valid = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if ({sum, carry, sum4, carry4} !== exp_comb()) begin
        failures++;
        $display("FAIL random_comb_%0d got=%b exp=%b",
                 i, {sum, carry, sum4, carry4}, exp_comb());
      end
      step();
      checks++;
      if (act_regs() !== exp_regs()) begin
        failures++;
        $display("FAIL random_regs_%0d got=%h exp=%h",
                 i, act_regs(), exp_regs());
      end
    end
    in_valid = 0;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_truth_table();
    clk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    test_registered();
    test_stats();
    test_back_to_back();
    test_x_idle();
    test_saturation();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
